// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter whose bits are stored as JK cells, with
// parallel load (clamped to the count range), terminal count and wrap pulse.
module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, qb_q;
    logic             wrap_q;

    logic [WIDTH-1:0] nxt_d, chg_d, j_d, k_d;
    logic             wrap_d, load_sel_d;

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_CNT) ? MAX_CNT : v;
    endfunction

    function automatic logic [WIDTH-1:0] jk_next(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] j,
                                                 input logic [WIDTH-1:0] k);
        return (j & ~cur) | (~k & cur);
    endfunction

    always_comb begin
        nxt_d      = q_q;
        wrap_d     = 1'b0;
        load_sel_d = 1'b0;
        if (load) begin
            nxt_d      = clamp_load(din);
            load_sel_d = 1'b1;
        end else if (en) begin
            if (up) begin
                if (q_q == MAX_CNT) begin
                    nxt_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    nxt_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    nxt_d  = MAX_CNT;
                    wrap_d = 1'b1;
                end else begin
                    nxt_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    // Changed bits get set/clear on a load and toggle (J=K=1) when counting.
    always_comb begin
        chg_d = nxt_d ^ q_q;
        j_d   = chg_d & (load_sel_d ? nxt_d  : {WIDTH{1'b1}});
        k_d   = chg_d & (load_sel_d ? ~nxt_d : {WIDTH{1'b1}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            qb_q   <= {WIDTH{1'b1}};
            wrap_q <= 1'b0;
        end else begin
            q_q    <= jk_next(q_q, j_d, k_d);
            qb_q   <= jk_next(qb_q, k_d, j_d);
            wrap_q <= wrap_d;
        end
    end

    assign q     = q_q;
    assign q_bar = qb_q;
    assign wrap  = wrap_q;
    assign tc    = up ? (q_q == MAX_CNT) : (q_q == '0);

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops
// and compares q, q_bar, wrap and tc one time unit after each rising edge.
module tb_jk_mod_counter;

    typedef struct {
        int         id;
        logic [3:0] q;
        logic       wrap;
        logic       tc;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass = 0;
    int   n_fail = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 0: WIDTH=4, MODULUS=10
    logic       rst0 = 1'b1, en0 = 1'b0, up0 = 1'b1, load0 = 1'b0;
    logic [3:0] din0 = '0, q0, qb0;
    logic       tc0, wrap0;
    // DUT 1: WIDTH=1, MODULUS=2
    logic       rst1 = 1'b1, en1 = 1'b0, up1 = 1'b1, load1 = 1'b0;
    logic [0:0] din1 = '0, q1, qb1;
    logic       tc1, wrap1;
    // DUT 2: WIDTH=4, MODULUS=16
    logic       rst2 = 1'b1, en2 = 1'b0, up2 = 1'b1, load2 = 1'b0;
    logic [3:0] din2 = '0, q2, qb2;
    logic       tc2, wrap2;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut0 (
        .clk(clk), .rst(rst0), .en(en0), .up(up0), .load(load0), .din(din0),
        .q(q0), .q_bar(qb0), .tc(tc0), .wrap(wrap0));
    jk_mod_counter #(.WIDTH(1), .MODULUS(2)) dut1 (
        .clk(clk), .rst(rst1), .en(en1), .up(up1), .load(load1), .din(din1),
        .q(q1), .q_bar(qb1), .tc(tc1), .wrap(wrap1));
    jk_mod_counter #(.WIDTH(4), .MODULUS(16)) dut2 (
        .clk(clk), .rst(rst2), .en(en2), .up(up2), .load(load2), .din(din2),
        .q(q2), .q_bar(qb2), .tc(tc2), .wrap(wrap2));

    task automatic step(input int id, input logic r, input logic e, input logic u,
                        input logic l, input logic [3:0] d,
                        input logic [3:0] eq, input logic ew, input logic et);
        exp_t x;
        en0 = 1'b0; load0 = 1'b0;
        en1 = 1'b0; load1 = 1'b0;
        en2 = 1'b0; load2 = 1'b0;
        case (id)
            0: begin rst0 = r; en0 = e; up0 = u; load0 = l; din0 = d; end
            1: begin rst1 = r; en1 = e; up1 = u; load1 = l; din1 = d[0]; end
            default: begin rst2 = r; en2 = e; up2 = u; load2 = l; din2 = d; end
        endcase
        @(posedge clk);
        x.id = id; x.q = eq; x.wrap = ew; x.tc = et;
        exp_q.push_back(x);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        while (exp_q.size() > 0) begin
            exp_t x;
            logic [3:0] aq, aqb, rq, rqb;
            logic       aw, at;
            x = exp_q.pop_front();
            case (x.id)
                0: begin aq = q0; aqb = qb0; aw = wrap0; at = tc0;
                         rq = x.q; rqb = ~x.q; end
                1: begin aq = {3'b0, q1}; aqb = {3'b0, qb1}; aw = wrap1; at = tc1;
                         rq = {3'b0, x.q[0]}; rqb = {3'b0, ~x.q[0]}; end
                default: begin aq = q2; aqb = qb2; aw = wrap2; at = tc2;
                         rq = x.q; rqb = ~x.q; end
            endcase
            if (aq === rq && aqb === rqb && aw === x.wrap && at === x.tc) begin
                n_pass++;
            end else begin
                n_fail++;
                $display("FAIL dut%0d t=%0t: got q=%h q_bar=%h wrap=%b tc=%b, required q=%h q_bar=%h wrap=%b tc=%b",
                         x.id, $time, aq, aqb, aw, at, rq, rqb, x.wrap, x.tc);
            end
        end
    end

    initial begin
        #2;
        // Reset dominates load and en
        step(0, 1, 1, 1, 1, 5, 0, 0, 0);
        step(0, 1, 1, 1, 1, 5, 0, 0, 0);
        // Up count 1..9, wrap to 0, then 1, 2
        for (int i = 1; i <= 9; i++)
            step(0, 0, 1, 1, 0, 0, 4'(i), 0, (i == 9));
        step(0, 0, 1, 1, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0, 2, 0, 0);
        // Load 0 with up=0 (tc high at 0), then count down with wrap
        step(0, 0, 0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 9, 1, 0);
        step(0, 0, 1, 0, 0, 0, 8, 0, 0);
        step(0, 0, 1, 0, 0, 0, 7, 0, 0);
        // Load and clamp
        step(0, 0, 0, 1, 1, 7, 7, 0, 0);
        step(0, 0, 0, 1, 1, 13, 9, 0, 1);
        step(0, 0, 1, 1, 1, 3, 3, 0, 0);
        step(0, 0, 0, 0, 1, 15, 9, 0, 0);
        step(0, 0, 1, 0, 0, 0, 8, 0, 0);
        // Hold at 4, then direction flip every edge
        step(0, 0, 0, 1, 1, 4, 4, 0, 0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 1, 0, 0, 4, 0, 0);
        step(0, 0, 1, 1, 0, 0, 5, 0, 0);
        step(0, 0, 1, 0, 0, 0, 4, 0, 0);
        step(0, 0, 1, 1, 0, 0, 5, 0, 0);
        step(0, 0, 1, 0, 0, 0, 4, 0, 0);
        // Reset mid-count
        step(0, 1, 1, 1, 1, 6, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 1, 0, 0);

        // MODULUS=2, WIDTH=1
        step(1, 1, 0, 1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 1, 0, 1);
        step(1, 0, 1, 1, 0, 0, 0, 1, 0);
        step(1, 0, 1, 1, 0, 0, 1, 0, 1);
        step(1, 0, 1, 1, 0, 0, 0, 1, 0);
        // Back-to-back wraps by alternating direction
        step(1, 0, 1, 0, 0, 0, 1, 1, 0);
        step(1, 0, 1, 1, 0, 0, 0, 1, 0);

        // MODULUS=16, WIDTH=4: natural binary wrap both ways
        step(2, 1, 0, 1, 0, 0, 0, 0, 0);
        step(2, 0, 0, 1, 1, 14, 14, 0, 0);
        step(2, 0, 1, 1, 0, 0, 15, 0, 1);
        step(2, 0, 1, 1, 0, 0, 0, 1, 0);
        step(2, 0, 1, 1, 0, 0, 1, 0, 0);
        step(2, 0, 1, 0, 0, 0, 0, 0, 1);
        step(2, 0, 1, 0, 0, 0, 15, 1, 0);
        step(2, 0, 1, 0, 0, 0, 14, 0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++)
            @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
